// File: rtl/life_pkg.sv
// Shared constants and FSM encoding for the life grid scheduler.
package life_pkg;
    localparam int ADDR_W     = 6;
    localparam int GEN_CYCLES = 4;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        GEN     = 2'd2,
        BUSY    = 2'd3
    } gen_state_t;
endpackage

// File: rtl/life_tick_timer.sv
// Generation period counter; period = TICK_DIV >> speed_sel, 1-cycle expiry strobe.
module life_tick_timer #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] speed_sel,
    output logic       expire
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;

    // >= so that a speed_sel increase below the current count fires at once
    assign last   = CNT_W'((TICK_DIV >> speed_sel) - 1);
    assign expire = en && (count >= last);

    always_ff @(posedge clk) begin
        if (rst || !en)
            count <= '0;
        else if (expire)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/life_gen_scheduler.sv
// Generation sequencer and grid write-port arbiter for envolve_logic.
// LIFE_GEN_COUNT_EN adds a 16-bit wrapping gen_count output.
module life_gen_scheduler #(
    parameter int ADDR_W     = life_pkg::ADDR_W,
    parameter int TICK_DIV   = 25000000,
    parameter int GEN_CYCLES = life_pkg::GEN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_toggle,
    input  logic              step_req,
    input  logic [1:0]        speed_sel,
    input  logic              edit_req,
    input  logic [ADDR_W-1:0] edit_row,
    input  logic [ADDR_W-1:0] edit_col,
    input  logic              edit_data,
    output logic              edit_ack,
    input  logic [ADDR_W-1:0] disp_row,
    input  logic [ADDR_W-1:0] disp_col,
    output logic              disp_data,
    output logic              running,
    output logic              busy,
    output logic              change_state,
    output logic              write_en,
    output logic [ADDR_W-1:0] wAddrR,
    output logic [ADDR_W-1:0] wAddrC,
    output logic              write_data,
    output logic [ADDR_W-1:0] rAddrR,
    output logic [ADDR_W-1:0] rAddrC,
    input  logic              read_data
`ifdef LIFE_GEN_COUNT_EN
    ,
    output logic [15:0]       gen_count
`endif
);
    import life_pkg::*;

    localparam int BC_W = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1;

    gen_state_t      state, state_nxt;
    logic            run_flag, run_nxt;
    logic            pending, pending_nxt;
    logic            gen_trig, edit_grant, tick_exp;
    logic [BC_W-1:0] busy_cnt;

    life_tick_timer #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RUNNING),
        .speed_sel (speed_sel),
        .expire    (tick_exp)
    );

    // the ack cycle blocks a regrant, so a held request is resampled first
    assign edit_grant = (state == PAUSED || state == RUNNING) && edit_req && !edit_ack;

    always_comb begin
        state_nxt   = state;
        run_nxt     = run_flag ^ run_toggle;
        pending_nxt = pending;
        gen_trig    = 1'b0;
        case (state)
            PAUSED:  if (run_toggle) state_nxt = RUNNING;
                     else gen_trig = step_req || pending;
            RUNNING: if (run_toggle) state_nxt = PAUSED;
                     else gen_trig = tick_exp || pending;
            GEN:     state_nxt = BUSY;
            BUSY:    if (busy_cnt == BC_W'(GEN_CYCLES - 1))
                         state_nxt = run_nxt ? RUNNING : PAUSED;
            default: state_nxt = PAUSED;
        endcase
        // an edit owns the port this cycle; the generation waits one slot
        if (gen_trig) begin
            if (edit_grant) begin
                pending_nxt = 1'b1;
            end else begin
                state_nxt   = GEN;
                pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PAUSED;
            run_flag   <= 1'b0;
            pending    <= 1'b0;
            busy_cnt   <= '0;
            edit_ack   <= 1'b0;
            wAddrR     <= '0;
            wAddrC     <= '0;
            write_data <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_flag <= run_nxt;
            pending  <= pending_nxt;
            busy_cnt <= (state == BUSY) ? busy_cnt + 1'b1 : '0;
            edit_ack <= edit_grant;
            if (edit_grant) begin
                wAddrR     <= edit_row;
                wAddrC     <= edit_col;
                write_data <= edit_data;
            end
        end
    end

`ifdef LIFE_GEN_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            gen_count <= '0;
        else if (state == GEN)
            gen_count <= gen_count + 16'd1;
    end
`endif

    assign write_en     = edit_ack;
    assign change_state = (state == GEN);
    assign busy         = (state == GEN) || (state == BUSY);
    assign running      = run_flag;
    assign rAddrR       = disp_row;
    assign rAddrC       = disp_col;
    assign disp_data    = read_data;
endmodule
